handshake_rx_arb: RTL and testbench

//  Multi-channel receive side of the two-phase (toggle) request/acknowledge handshake.
//  NUM_CH remote senders each drive a toggle request and hold a DATA_W word.

---
 rtl/hs_rx_pkg.sv | 40 ++++
 rtl/toggle_sync_det.sv | 26 ++
 rtl/handshake_rx_arb.sv | 129 ++++++++++++
 tb/tb_handshake_rx_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_rx_pkg.sv
// Shared types and helpers for the toggle-handshake receive arbiter.
// rr_pick is sized for the 16-channel maximum so one function serves every NUM_CH.
package hs_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } ch_state_e;

  localparam int MAX_CH = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of pend at or after ptr, wrapping at n; the descending loop lets the smallest offset win.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pend,
                                       input logic [3:0]        ptr,
                                       input int                n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (pend[idx]) begin
          r.found = 1'b1;
          r.idx   = idx[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/toggle_sync_det.sv
// Synchronises one foreign-domain request toggle and emits a single-cycle pulse per level change.
module toggle_sync_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_req_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_req_pulse = r_sync[SYNC_STAGES-1] ^ r_last;

endmodule

// File: rtl/handshake_rx_arb.sv
// Merges NUM_CH toggle-handshake senders onto one valid/ready stream with round-robin grant.
// Stream handshake: a word transfers on any edge where out_valid && out_ready; out_data/out_ch hold while stalled.
module handshake_rx_arb
  import hs_rx_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DATA_W      = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_level,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic [NUM_CH-1:0]        ack_level,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        err_ovf
);

  logic [NUM_CH-1:0] w_req_pulse;
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_err_set;
  logic [MAX_CH-1:0] w_pend_ext;
  rr_pick_t          w_pick;
  logic              w_load;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_ptr_nxt;

  // Per-channel FSM state, visible hierarchically for checkers.
  ch_state_e         r_state     [NUM_CH];
  ch_state_e         w_state_nxt [NUM_CH];
  logic [DATA_W-1:0] r_hold      [NUM_CH];

  logic [CH_W-1:0]   r_rr_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [NUM_CH-1:0] r_ack;
  logic [NUM_CH-1:0] r_err;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    toggle_sync_det #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
      .clk        (clk),
      .reset      (reset),
      .i_level    (req_level[gi]),
      .o_req_pulse(w_req_pulse[gi])
    );
  end

  always_comb begin
    w_pend_ext = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pend[i]     = (r_state[i] == PEND);
      w_pend_ext[i] = w_pend[i];
    end

    w_pick    = rr_pick(w_pend_ext, 4'(r_rr_ptr), NUM_CH);
    w_load    = w_pick.found && (!r_out_valid || out_ready);
    w_gnt_idx = CH_W'(w_pick.idx);
    w_ptr_nxt = (int'(w_gnt_idx) == NUM_CH - 1) ? '0 : w_gnt_idx + 1'b1;

    for (int i = 0; i < NUM_CH; i++) begin
      w_grant[i]     = w_load && (w_pick.idx == 4'(i));
      w_state_nxt[i] = r_state[i];
      w_err_set[i]   = 1'b0;
      case (r_state[i])
        IDLE: if (w_req_pulse[i]) w_state_nxt[i] = PEND;
        PEND: begin
          if (w_grant[i])     w_state_nxt[i] = IDLE;
          // A second toggle before grant is a sender protocol error; the held word is kept.
          if (w_req_pulse[i]) w_err_set[i]   = 1'b1;
        end
        default: w_state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= IDLE;
        r_hold[i]  <= '0;
      end
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ack       <= '0;
      r_err       <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (r_state[i] == IDLE && w_req_pulse[i])
          r_hold[i] <= data_in[i*DATA_W +: DATA_W];
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_hold[w_gnt_idx];
        r_out_ch    <= w_gnt_idx;
        r_rr_ptr    <= w_ptr_nxt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // The ack goes back only once the consumer has taken the word.
      if (r_out_valid && out_ready) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_out_ch == CH_W'(i)) r_ack[i] <= ~r_ack[i];
        end
      end

      r_err <= r_err | w_err_set;
    end
  end

  assign ack_level = r_ack;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign err_ovf   = r_err;

endmodule

// File: tb/tb_handshake_rx_arb.sv
// Bench for handshake_rx_arb: model senders, per-channel expected-word queues and an ack-level model.
module tb_handshake_rx_arb;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        req_level;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        ack_level;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
  logic [NUM_CH-1:0]        err_ovf;

  int checks   = 0;
  int failures = 0;
  int n_sent   = 0;
  int n_acc    = 0;

  logic [DATA_W-1:0] exp_q [NUM_CH][$];
  logic [CH_W-1:0]   exp_ch_q[$];
  logic [NUM_CH-1:0] m_ack;
  logic              mon_en = 1'b0;

  handshake_rx_arb #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_level(req_level),
    .data_in  (data_in),
    .ack_level(ack_level),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_ready(out_ready),
    .err_ovf  (err_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int q_total();
    int t = 0;
    for (int c = 0; c < NUM_CH; c++) t += exp_q[c].size();
    return t;
  endfunction

  // monitor / scoreboard
  initial begin
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [CH_W-1:0]   prev_ch;
    logic [DATA_W-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_ch    = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("ack_level", 32'(ack_level), 32'(m_ack));
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(prev_data));
          check("stall_ch", 32'(out_ch), 32'(prev_ch));
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q[out_ch].size() == 0) begin
            failures++;
            $display("FAIL word: ch %0d data %0h delivered, expected no word", out_ch, out_data);
          end else begin
            e = exp_q[out_ch].pop_front();
            if (out_data !== e) begin
              failures++;
              $display("FAIL word: ch %0d got %0h expected %0h", out_ch, out_data, e);
            end
          end
          if (exp_ch_q.size() > 0) check("rr_order", 32'(out_ch), 32'(exp_ch_q.pop_front()));
          m_ack[out_ch] = ~m_ack[out_ch];
          n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_ch    = out_ch;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [DATA_W-1:0] d);
    data_in[ch*DATA_W +: DATA_W] = d;
    req_level[ch] = ~req_level[ch];
    exp_q[ch].push_back(d);
    n_sent++;
  endtask

  task automatic wait_valid(input string name, input int max);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < max) begin
      @(negedge clk);
      n++;
      seen = out_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: out_valid not seen within %0d cycles", name, max);
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int n    = 0;
    bit done = 1'b0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
      done = (q_total() == 0) && !out_valid;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: drain timeout, %0d words outstanding", name, q_total());
    end
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    reset     = 1'b1;
    req_level = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_ack_level", 32'(ack_level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    exp_ch_q.delete();
    m_ack  = '0;
    n_sent = 0;
    n_acc  = 0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    req_level = '0;
    data_in   = '0;
    out_ready = 1'b0;
    m_ack     = '0;
    do_reset();

    // single word: toggle sampled at edge k, valid after edge k+3, ack one edge after accept
    out_ready = 1'b1;
    tick();
    send(0, 8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'hA5);
    check("t1_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    check("t1_ack", 32'(ack_level[0]), 32'd1);

    // backpressure for 10 cycles
    tick();
    out_ready = 1'b0;
    send(1, 8'h3C);
    wait_valid("t2_valid", 20);
    repeat (10) @(negedge clk);
    check("t2_hold_valid", 32'(out_valid), 32'd1);
    check("t2_ack_held", 32'(ack_level[1]), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_ack_not_early", 32'(ack_level[1]), 32'd0);
    @(negedge clk);
    check("t2_ack", 32'(ack_level[1]), 32'd1);
    wait_drain("t2_drain", 20);

    // reset with ch0 in the output register and ch1 pending
    tick();
    out_ready = 1'b0;
    send(0, 8'h11);
    wait_valid("t3_valid", 20);
    tick();
    send(1, 8'h22);
    repeat (5) tick();
    do_reset();
    out_ready = 1'b1;
    send(3, 8'h5A);
    wait_drain("t3_fresh", 30);
    check("t3_fresh_count", 32'(n_acc), 32'd1);

    // fairness: all four together, then ch0+ch3 after the wrap
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      send(c, 8'($urandom_range(0, 255)));
      exp_ch_q.push_back(CH_W'(c));
    end
    wait_drain("t4_round1", 40);
    tick();
    send(0, 8'($urandom_range(0, 255)));
    send(3, 8'($urandom_range(0, 255)));
    exp_ch_q.push_back(2'd0);
    exp_ch_q.push_back(2'd3);
    wait_drain("t4_round2", 40);
    check("t4_order_used", 32'(exp_ch_q.size()), 32'd0);

    // overflow: ch2 toggles twice while pending behind a stalled ch1 word
    tick();
    out_ready = 1'b0;
    send(1, 8'h77);
    wait_valid("t5_valid", 20);
    tick();
    send(2, 8'h88);
    repeat (6) tick();
    data_in[2*DATA_W +: DATA_W] = 8'hEE;
    req_level[2] = ~req_level[2];
    repeat (6) tick();
    @(negedge clk);
    check("t5_ovf_flag", 32'(err_ovf), 32'h4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("t5_drain", 30);
    repeat (10) @(negedge clk);
    check("t5_ovf_sticky", 32'(err_ovf), 32'h4);
    check("t5_single_ack", 32'(ack_level[2]), 32'd0);

    // randomized traffic with random backpressure, then a full-speed phase
    tick();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      out_ready = (cyc >= 1100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_level[c] == ack_level[c] && $urandom_range(0, 2) != 0)
          send(c, 8'($urandom_range(0, 255)));
      end
    end
    tick();
    out_ready = 1'b1;
    wait_drain("rand_drain", 200);
    check("rand_count", 32'(n_acc), 32'(n_sent));
    check("rand_no_ovf", 32'(err_ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
